// File: rtl/eth_bridge_pkg.sv
// Shared definitions for the Ethernet bridge datapath: frame-size limits,
// receive-controller state encodings and the frame-length type.
package eth_bridge_pkg;

    localparam int MIN_FRAME_LEN = 60;
    localparam int MAX_FRAME_LEN = 1518;

    typedef logic [15:0] frame_len_t;

    typedef enum logic [3:0] {
        RX_IDLE   = 4'b0001,
        RX_RECV   = 4'b0010,
        RX_DROP   = 4'b0100,
        RX_COMMIT = 4'b1000
    } rx_state_e;

    function automatic frame_len_t sat_inc16(input frame_len_t v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/len_fifo.sv
// First-word-fall-through FIFO of frame lengths; head is valid whenever
// o_empty is low. Pushes while full and pops while empty are ignored.
module len_fifo
    import eth_bridge_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  frame_len_t i_din,
    input  logic       i_pop,
    output frame_len_t o_head,
    output logic       o_empty,
    output logic       o_full
);

    localparam int DEPTH = 1 << AW;

    frame_len_t    r_mem [DEPTH];
    logic [AW:0]   r_wp;
    logic [AW:0]   r_rp;
    logic          w_push_ok;
    logic          w_pop_ok;

    // Extra pointer bit separates full from empty when the low bits match.
    assign o_empty   = (r_wp == r_rp);
    assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + 1'b1;
            if (w_pop_ok)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wp[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/rx_control.sv
// Receive controller: buffers incoming frames, commits good ones to the
// reader and rolls back errored, short, long or non-fitting frames.
module rx_control
    import eth_bridge_pkg::*;
#(
    parameter int BUF_AW  = 11,
    parameter int LEN_AW  = 4,
    parameter int MIN_LEN = MIN_FRAME_LEN,
    parameter int MAX_LEN = MAX_FRAME_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    input  logic        rx_last_byte,
    input  logic        rx_error,
    output logic        rx_ready,
    output logic [7:0]  buf_data,
    input  logic        next_byte,
    output logic [15:0] frm_len,
    input  logic        next_len,
    output logic        empty_buff,
    output logic        empty_len_buff,
    output logic [15:0] drop_cnt,
    output logic [3:0]  o_dbg_state
);

    localparam int                PW    = BUF_AW + 1;
    localparam logic [PW-1:0]     DEPTH = PW'(1) << BUF_AW;
    localparam frame_len_t        MIN_L = frame_len_t'(MIN_LEN);
    localparam frame_len_t        MAX_L = frame_len_t'(MAX_LEN);

    logic [7:0]    r_mem [1 << BUF_AW];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_commit_ptr;
    logic [PW-1:0] r_rd_ptr;
    frame_len_t    r_cnt;
    frame_len_t    r_drop_cnt;
    rx_state_e     r_state;
    logic          r_rx_ready;

    logic [PW-1:0] w_used;
    logic [PW-1:0] w_free;
    logic          w_buf_full;
    logic          w_accept;
    logic          w_in_frame;
    logic          w_cnt_at_max;
    frame_len_t    w_next_cnt;
    logic          w_eof_bad;
    logic          w_wr_en;
    logic          w_empty;
    logic          w_rd_adv;
    logic          w_lq_push;
    frame_len_t    w_lq_head;
    logic          w_lq_empty;
    logic          w_lq_full;

    // Free space uses the pre-edge read pointer, so a same-cycle pop is
    // only seen one cycle later (never overstates space).
    assign w_used       = r_wr_ptr - r_rd_ptr;
    assign w_free       = DEPTH - w_used;
    assign w_buf_full   = (w_free == '0);
    assign w_accept     = rx_data_valid && r_rx_ready;
    assign w_in_frame   = (r_state == RX_IDLE) || (r_state == RX_RECV);
    assign w_cnt_at_max = (r_state == RX_RECV) && (r_cnt == MAX_L);
    assign w_next_cnt   = (r_state == RX_IDLE) ? 16'd1 : r_cnt + 16'd1;
    assign w_eof_bad    = rx_error || (w_next_cnt < MIN_L) || (w_next_cnt > MAX_L) || w_lq_full;
    assign w_wr_en      = w_accept && w_in_frame && !w_buf_full && !(w_cnt_at_max && !rx_last_byte);

    assign w_empty      = (r_rd_ptr == r_commit_ptr);
    assign w_rd_adv     = next_byte && !w_empty;
    assign w_lq_push    = (r_state == RX_COMMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_cnt        <= '0;
            r_drop_cnt   <= '0;
            r_state      <= RX_IDLE;
            r_rx_ready   <= 1'b0;
        end else begin
            r_rx_ready <= 1'b1;
            case (r_state)
                RX_IDLE, RX_RECV: begin
                    if (w_accept) begin
                        if (w_buf_full) begin
                            r_wr_ptr <= r_commit_ptr;
                            if (rx_last_byte) begin
                                r_drop_cnt <= sat_inc16(r_drop_cnt);
                                r_state    <= RX_IDLE;
                            end else begin
                                r_state <= RX_DROP;
                            end
                        end else if (rx_last_byte) begin
                            if (w_eof_bad) begin
                                r_wr_ptr   <= r_commit_ptr;
                                r_drop_cnt <= sat_inc16(r_drop_cnt);
                                r_state    <= RX_IDLE;
                            end else begin
                                r_wr_ptr   <= r_wr_ptr + 1'b1;
                                r_cnt      <= w_next_cnt;
                                r_state    <= RX_COMMIT;
                                r_rx_ready <= 1'b0;
                            end
                        end else if (w_cnt_at_max) begin
                            // Frame already holds MAX_LEN bytes and is still going.
                            r_wr_ptr <= r_commit_ptr;
                            r_state  <= RX_DROP;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            r_cnt    <= w_next_cnt;
                            r_state  <= RX_RECV;
                        end
                    end
                end
                RX_COMMIT: begin
                    r_commit_ptr <= r_wr_ptr;
                    r_state      <= RX_IDLE;
                end
                RX_DROP: begin
                    if (w_accept && rx_last_byte) begin
                        r_drop_cnt <= sat_inc16(r_drop_cnt);
                        r_state    <= RX_IDLE;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_rd_adv) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[BUF_AW-1:0]] <= rx_data;
    end

    len_fifo #(
        .AW (LEN_AW)
    ) u_len_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_lq_push),
        .i_din   (r_cnt),
        .i_pop   (next_len),
        .o_head  (w_lq_head),
        .o_empty (w_lq_empty),
        .o_full  (w_lq_full)
    );

    assign rx_ready       = r_rx_ready;
    assign buf_data       = w_empty ? 8'h00 : r_mem[r_rd_ptr[BUF_AW-1:0]];
    assign empty_buff     = w_empty;
    assign frm_len        = w_lq_empty ? 16'h0000 : w_lq_head;
    assign empty_len_buff = w_lq_empty;
    assign drop_cnt       = r_drop_cnt;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_rx_control.sv
// Directed bench for rx_control: three instances (default, 128-byte buffer,
// 2-entry length queue) driven one at a time through a shared stimulus bus.
module tb_rx_control;
    import eth_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic        rx_last_byte;
    logic        rx_error;
    logic        next_byte;
    logic        next_len;
    int          sel;

    logic        rdy [3];
    logic [7:0]  bd  [3];
    logic [15:0] fl  [3];
    logic        eb  [3];
    logic        el  [3];
    logic [15:0] dc  [3];
    logic [3:0]  st  [3];

    logic [7:0]  exp_q[$];
    logic [15:0] len_q[$];

    int errors = 0;
    int checks = 0;
    int probe_idx = -1;
    logic [3:0] probe_state;
    int stalls;
    int exp_drop;

    always #5 clk = ~clk;

    rx_control u_dut0 (
        .clk(clk), .rst(rst), .rx_data(rx_data),
        .rx_data_valid(rx_data_valid && sel == 0), .rx_last_byte(rx_last_byte), .rx_error(rx_error),
        .rx_ready(rdy[0]), .buf_data(bd[0]), .next_byte(next_byte && sel == 0), .frm_len(fl[0]),
        .next_len(next_len && sel == 0), .empty_buff(eb[0]), .empty_len_buff(el[0]),
        .drop_cnt(dc[0]), .o_dbg_state(st[0])
    );

    rx_control #(.BUF_AW(7)) u_dut1 (
        .clk(clk), .rst(rst), .rx_data(rx_data),
        .rx_data_valid(rx_data_valid && sel == 1), .rx_last_byte(rx_last_byte), .rx_error(rx_error),
        .rx_ready(rdy[1]), .buf_data(bd[1]), .next_byte(next_byte && sel == 1), .frm_len(fl[1]),
        .next_len(next_len && sel == 1), .empty_buff(eb[1]), .empty_len_buff(el[1]),
        .drop_cnt(dc[1]), .o_dbg_state(st[1])
    );

    rx_control #(.LEN_AW(1)) u_dut2 (
        .clk(clk), .rst(rst), .rx_data(rx_data),
        .rx_data_valid(rx_data_valid && sel == 2), .rx_last_byte(rx_last_byte), .rx_error(rx_error),
        .rx_ready(rdy[2]), .buf_data(bd[2]), .next_byte(next_byte && sel == 2), .frm_len(fl[2]),
        .next_len(next_len && sel == 2), .empty_buff(eb[2]), .empty_len_buff(el[2]),
        .drop_cnt(dc[2]), .o_dbg_state(st[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives len beats; good frames have their bytes and length queued as expected output.
    task automatic send_frame(input int len, input logic [7:0] base, input logic err,
                              input logic do_last, input logic good);
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            rx_data       = base + 8'(i);
            rx_data_valid = 1'b1;
            rx_last_byte  = do_last && (i == len - 1);
            rx_error      = err && rx_last_byte;
            while (rdy[sel] !== 1'b1 && stalls <= 100) begin
                stalls++;
                tick();
            end
            if (stalls > 100) begin
                check("ready_timeout", 32'(stalls), 32'd0);
                rx_data_valid = 1'b0;
                rx_last_byte  = 1'b0;
                rx_error      = 1'b0;
                return;
            end
            if (good) exp_q.push_back(rx_data);
            tick();
            if (i == probe_idx) probe_state = st[sel];
        end
        rx_data_valid = 1'b0;
        rx_last_byte  = 1'b0;
        rx_error      = 1'b0;
        if (good) len_q.push_back(16'(len));
    endtask

    task automatic read_frame();
        logic [15:0] exp_len;
        if (len_q.size() == 0) begin
            check("len_q_underflow", 32'(len_q.size()), 32'd1);
            return;
        end
        exp_len = len_q.pop_front();
        check("empty_len_buff", el[sel], 1'b0);
        check("frm_len", fl[sel], exp_len);
        for (int i = 0; i < int'(exp_len); i++) begin
            check("empty_buff_mid", eb[sel], 1'b0);
            if (exp_q.size() > 0) check("buf_data", bd[sel], exp_q.pop_front());
            next_byte = 1'b1;
            tick();
            next_byte = 1'b0;
        end
        next_len = 1'b1;
        tick();
        next_len = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_data = '0; rx_data_valid = 1'b0; rx_last_byte = 1'b0;
        rx_error = 1'b0; next_byte = 1'b0; next_len = 1'b0; sel = 0; exp_drop = 0;
        repeat (3) tick();
        check("rst_ready", rdy[0], 1'b0);
        check("rst_empty_buff", eb[0], 1'b1);
        check("rst_empty_len", el[0], 1'b1);
        check("rst_frm_len", fl[0], 16'h0);
        check("rst_buf_data", bd[0], 8'h0);
        check("rst_drop_cnt", dc[0], 16'h0);
        check("rst_state", st[0], 32'(RX_IDLE));
        rst = 1'b0;
        tick();
        check("ready_after_rst", rdy[0], 1'b1);

        // Good 64-byte frame: one-cycle commit bubble, then visible.
        send_frame(64, 8'h00, 1'b0, 1'b1, 1'b1);
        check("commit_ready_low", rdy[0], 1'b0);
        check("commit_state", st[0], 32'(RX_COMMIT));
        check("commit_len_still_empty", el[0], 1'b1);
        tick();
        check("post_commit_ready", rdy[0], 1'b1);
        check("post_commit_empty_buff", eb[0], 1'b0);
        read_frame();
        check("drained_empty_buff", eb[0], 1'b1);
        check("drained_empty_len", el[0], 1'b1);
        check("drained_buf_data", bd[0], 8'h0);
        check("drained_frm_len", fl[0], 16'h0);

        // Errored frame is rolled back; next good frame follows cleanly.
        send_frame(64, 8'h10, 1'b1, 1'b1, 1'b0);
        exp_drop++;
        check("err_ready", rdy[0], 1'b1);
        check("err_drop_cnt", dc[0], 32'(exp_drop));
        tick();
        check("err_empty_buff", eb[0], 1'b1);
        check("err_empty_len", el[0], 1'b1);
        send_frame(60, 8'h80, 1'b0, 1'b1, 1'b1);
        tick();
        read_frame();

        // Length boundaries: 40 and 59 short, 1600 long, 1518 accepted.
        send_frame(40, 8'h20, 1'b0, 1'b1, 1'b0);
        exp_drop++;
        send_frame(59, 8'h30, 1'b0, 1'b1, 1'b0);
        exp_drop++;
        check("short_drop_cnt", dc[0], 32'(exp_drop));
        probe_idx = 1518;
        send_frame(1600, 8'h05, 1'b0, 1'b1, 1'b0);
        probe_idx = -1;
        exp_drop++;
        check("long_beat1519_state", probe_state, 32'(RX_DROP));
        check("long_no_stalls", 32'(stalls), 32'd0);
        check("long_drop_cnt", dc[0], 32'(exp_drop));
        check("long_state_idle", st[0], 32'(RX_IDLE));
        tick();
        check("long_empty_buff", eb[0], 1'b1);
        check("long_empty_len", el[0], 1'b1);
        send_frame(1518, 8'h33, 1'b0, 1'b1, 1'b1);
        tick();
        read_frame();

        // 128-byte buffer: overflow drop, then a frame that wraps the pointers.
        sel = 1;
        send_frame(100, 8'h00, 1'b0, 1'b1, 1'b1);
        tick();
        send_frame(60, 8'hA0, 1'b0, 1'b1, 1'b0);
        check("ovf_drop_cnt", dc[1], 32'd1);
        check("ovf_frm_len", fl[1], 32'd100);
        read_frame();
        check("ovf_drained", eb[1], 1'b1);
        send_frame(60, 8'hC0, 1'b0, 1'b1, 1'b1);
        tick();
        read_frame();
        check("wrap_drained", eb[1], 1'b1);

        // Two-entry length queue: third frame dropped until a length is popped.
        sel = 2;
        send_frame(60, 8'h00, 1'b0, 1'b1, 1'b1);
        tick();
        send_frame(61, 8'h40, 1'b0, 1'b1, 1'b1);
        tick();
        send_frame(62, 8'h90, 1'b0, 1'b1, 1'b0);
        check("lq_full_drop_cnt", dc[2], 32'd1);
        read_frame();
        send_frame(63, 8'hD0, 1'b0, 1'b1, 1'b1);
        check("lq_fourth_commit", st[2], 32'(RX_COMMIT));
        tick();
        read_frame();
        read_frame();
        check("lq_drained_len", el[2], 1'b1);
        check("lq_drained_buf", eb[2], 1'b1);

        // Reset mid-frame discards the partial frame and clears everything.
        sel = 0;
        send_frame(30, 8'h55, 1'b0, 1'b0, 1'b0);
        check("mid_state_recv", st[0], 32'(RX_RECV));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ready", rdy[0], 1'b0);
        check("mid_rst_empty_buff", eb[0], 1'b1);
        check("mid_rst_empty_len", el[0], 1'b1);
        check("mid_rst_frm_len", fl[0], 16'h0);
        check("mid_rst_buf_data", bd[0], 8'h0);
        check("mid_rst_drop_cnt", dc[0], 16'h0);
        check("mid_rst_state", st[0], 32'(RX_IDLE));
        tick();
        check("mid_rst_ready_after", rdy[0], 1'b1);
        send_frame(60, 8'h70, 1'b0, 1'b1, 1'b1);
        tick();
        read_frame();
        check("final_empty_buff", eb[0], 1'b1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("len_queue_empty", 32'(len_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_control.md
Name: rx_control

Overview:
- Receive-side counterpart of the bridge transmit controller.
- Accepts a byte stream with end-of-frame and error markers from the MAC RX interface.
- Stores whole frames in an internal byte buffer and publishes each good frame's length in a length queue.
- Frames that are errored, too short, too long or do not fit are dropped and rolled back. Only complete, good frames become visible to the downstream reader (the transmit path on the other port).

Parameters:
- BUF_AW, 11, log2 of byte-buffer depth (2048 bytes).
- LEN_AW, 4, log2 of length-queue depth (16 frames).
- MIN_LEN, 60, minimum accepted frame length in bytes.
- MAX_LEN, 1518, maximum accepted frame length in bytes.

Ports:
- clk  input  1  sole clock.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte from the MAC.
- rx_data_valid  input  1  rx_data is valid this cycle.
- rx_last_byte  input  1  qualifies the final byte of a frame.
- rx_error  input  1  sampled with rx_last_byte; 1 means the frame is bad (FCS or PHY error).
- rx_ready  output  1  block accepts a byte this cycle.
- buf_data  output  8  byte at the read pointer; 0 when empty_buff is 1.
- next_byte  input  1  pops one byte from the buffer.
- frm_len  output  16  length of the oldest committed frame; 0 when the queue is empty.
- next_len  input  1  pops one length entry.
- empty_buff  output  1  no committed bytes remain.
- empty_len_buff  output  1  length queue is empty.
- drop_cnt  output  16  count of dropped frames; saturates at 0xFFFF.

Behaviour:
- Reset (clk edge with rst=1) sets:
  - wr_ptr, commit_ptr and rd_ptr to 0; byte count to 0; length queue emptied.
  - state to IDLE; rx_ready=0 while rst=1, and 1 on the first cycle after.
  - empty_buff=1, empty_len_buff=1, frm_len=0, buf_data=0, drop_cnt=0.
- Reset mid-frame discards the partial frame; nothing is committed.
- Pointers are BUF_AW+1 bits wide; the MSB distinguishes wrap.
  - free = 2^BUF_AW - (wr_ptr - rd_ptr), computed modulo 2^(BUF_AW+1).
- A beat is accepted when rx_data_valid && rx_ready.
- States: IDLE, RECV, DROP, COMMIT (one-hot).
  - IDLE, rx_ready=1:
    - Accepted beat with free>0: write mem[wr_ptr], wr_ptr+1, cnt=1, go to RECV. If the same beat has rx_last_byte, apply the end-of-frame check below.
    - Accepted beat with free==0: go to DROP, or count the drop directly if the beat is last.
  - RECV, rx_ready=1: each accepted non-last beat writes, increments wr_ptr and increments cnt.
    - If free==0, or cnt==MAX_LEN on a non-last beat: wr_ptr <= commit_ptr and go to DROP.
  - End-of-frame check on the accepted last beat, with len=cnt+1 (byte written):
    - If rx_error, or len<MIN_LEN, or len>MAX_LEN, or the length queue is full: wr_ptr <= commit_ptr, drop_cnt+1, go to IDLE.
    - Otherwise go to COMMIT.
  - COMMIT, rx_ready=0, one cycle: commit_ptr <= wr_ptr, push len into the length queue, go to IDLE.
  - DROP, rx_ready=1: beats are discarded; the accepted last beat does drop_cnt+1 and goes to IDLE.
- Latency: last beat accepted at cycle N, COMMIT at N+1, empty_buff and empty_len_buff low from N+2.
- Read side:
  - empty_buff = (rd_ptr == commit_ptr); buf_data = mem[rd_ptr], first-word-fall-through.
  - next_byte with !empty_buff advances rd_ptr; new data is visible the next cycle.
  - next_byte while empty is ignored; next_len while empty is ignored.
  - frm_len shows the head entry combinationally from the queue register.
- Simultaneous events:
  - A pop on the read side during COMMIT or a write is legal; free is computed from the pre-edge rd_ptr (conservative).
  - A length-queue push and pop in the same cycle keeps the occupancy unchanged.
- The reader owns consistency: it must pop exactly frm_len bytes per next_len.

Decomposition:
- Package eth_bridge_pkg holds MIN_FRAME_LEN=60, MAX_FRAME_LEN=1518, the rx state one-hot encodings, and the 16-bit frame-length type.
- One sub-module, len_fifo: synchronous FWFT FIFO, 16-bit wide, 2^LEN_AW deep, with push, pop, head, empty and full.
- The byte buffer and commit/rollback logic stay in rx_control.

Test Plan:
- Stream a 64-byte frame 0x00..0x3F with rx_error=0 -> rx_ready low for 1 cycle; empty_len_buff=0 two cycles after the last beat; frm_len=64; popping yields 0x00..0x3F, then empty_buff=1.
- Stream a 64-byte frame with rx_error=1 on the last beat -> empty_buff stays 1, drop_cnt=1, wr_ptr restored; the next good 60-byte frame gives frm_len=60.
- Stream a 40-byte frame, then a 1600-byte frame -> both dropped, drop_cnt=2; the 1519th beat moves to DROP and the remaining beats are discarded with rx_ready=1.
- BUF_AW=7 (128 B): commit 100 bytes without reading, then send a 60-byte frame -> overflow drop, drop_cnt=1; pop 100 bytes, resend 60 -> committed at pointer wrap, data intact.
- LEN_AW=1: commit 2 frames, send a third without popping -> third dropped despite byte space; after next_len the fourth frame commits.
- Assert rst for 1 cycle mid-frame after 30 beats -> all flags back to their reset values, drop_cnt=0; a following 60-byte frame is received correctly.
